// File: rtl/fxu_pkg.sv
`default_nettype none
// ============================================================================
// fxu_pkg : shared FXU opcodes, default widths and operand-need decode
// Rev 1.0
// ============================================================================
package fxu_pkg;

    localparam int DEPTH_DEF  = 4;
    localparam int ROB_W_DEF  = 4;
    localparam int DATA_W_DEF = 16;
    localparam int IMM_W_DEF  = 9;
    localparam int OP_W_DEF   = 4;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_MOV  = 4'b0100,
        OP_MOVL = 4'b0101,
        OP_MOVH = 4'b0110
    } fxu_op_e;

    // Operand slot positions inside the {t,a,b} need/ready vectors
    localparam int OPND_B = 0;
    localparam int OPND_A = 1;
    localparam int OPND_T = 2;

    function automatic logic [2:0] operand_need(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB:   return 3'b011;
            OP_MOV:           return 3'b010;
            OP_MOVL, OP_MOVH: return 3'b100;
            default:          return 3'b000;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/iq_oldest_picker.sv
`default_nettype none
// ============================================================================
// iq_oldest_picker : one-hot grant of the oldest ready entry (modulo ages)
// Rev 1.0
// ============================================================================
module iq_oldest_picker #(
    parameter int DEPTH = 4,
    parameter int AGE_W = 5
) (
    input  logic [DEPTH-1:0]            i_ready,
    input  logic [DEPTH-1:0][AGE_W-1:0] i_age,
    output logic [DEPTH-1:0]            o_grant,
    output logic                        o_any
);

    // a is older than b when (a - b) is negative in modulo-2^AGE_W arithmetic
    function automatic logic older(input logic [AGE_W-1:0] a, input logic [AGE_W-1:0] b);
        logic [AGE_W-1:0] diff;
        diff = a - b;
        return diff[AGE_W-1];
    endfunction

    always_comb begin
        o_grant = i_ready;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && i_ready[i] && i_ready[j]) begin
                    if (older(i_age[j], i_age[i]) || (i_age[j] == i_age[i] && j < i)) begin
                        o_grant[i] = 1'b0;
                    end
                end
            end
        end
    end

    assign o_any = |i_ready;

endmodule
`default_nettype wire

// File: rtl/fxu_issue_queue.sv
`default_nettype none
// ============================================================================
// fxu_issue_queue : FXU reservation station with CDB wakeup and oldest-first issue
// Rev 1.0
// ============================================================================
module fxu_issue_queue
    import fxu_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ROB_W  = ROB_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMM_W  = IMM_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     disp_valid,
    output logic                     disp_ready,
    input  logic [OP_W-1:0]          disp_opcode,
    input  logic [ROB_W-1:0]         disp_rob_index,
    input  logic [IMM_W-1:0]         disp_imm,
    input  logic                     disp_t_rdy,
    input  logic [ROB_W-1:0]         disp_t_tag,
    input  logic [DATA_W-1:0]        disp_t_val,
    input  logic                     disp_a_rdy,
    input  logic [ROB_W-1:0]         disp_a_tag,
    input  logic [DATA_W-1:0]        disp_a_val,
    input  logic                     disp_b_rdy,
    input  logic [ROB_W-1:0]         disp_b_tag,
    input  logic [DATA_W-1:0]        disp_b_val,
    input  logic                     cdb_valid,
    input  logic [ROB_W-1:0]         cdb_rob_index,
    input  logic [DATA_W-1:0]        cdb_value,
    output logic                     issue_valid,
    output logic [OP_W-1:0]          issue_opcode,
    output logic [ROB_W-1:0]         issue_rob_index,
    output logic [DATA_W-1:0]        issue_vt,
    output logic [DATA_W-1:0]        issue_va,
    output logic [DATA_W-1:0]        issue_vb,
    output logic [IMM_W-1:0]         issue_i,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam int AGE_W = ROB_W + 1;

    logic [DEPTH-1:0]            r_valid;
    logic [OP_W-1:0]             r_op   [DEPTH];
    logic [ROB_W-1:0]            r_rob  [DEPTH];
    logic [IMM_W-1:0]            r_imm  [DEPTH];
    logic [2:0]                  r_rdy  [DEPTH];
    logic [ROB_W-1:0]            r_tag  [DEPTH][3];
    logic [DATA_W-1:0]           r_val  [DEPTH][3];
    logic [DEPTH-1:0][AGE_W-1:0] r_age;
    logic [AGE_W-1:0]            r_age_ctr;
    logic [OCC_W-1:0]            r_occ;

    logic                        r_issue_valid;
    logic [OP_W-1:0]             r_issue_op;
    logic [ROB_W-1:0]            r_issue_rob;
    logic [DATA_W-1:0]           r_issue_vt;
    logic [DATA_W-1:0]           r_issue_va;
    logic [DATA_W-1:0]           r_issue_vb;
    logic [IMM_W-1:0]            r_issue_i;

    logic [DEPTH-1:0]            w_sel_rdy;
    logic [DEPTH-1:0]            w_grant;
    logic                        w_issue;
    logic [IDX_W-1:0]            w_sel_idx;
    logic [IDX_W-1:0]            w_free_idx;
    logic                        w_accept;
    logic [2:0]                  w_need;
    logic [2:0]                  w_d_rdy;
    logic [ROB_W-1:0]            w_d_tag [3];
    logic [DATA_W-1:0]           w_d_val [3];
    logic [2:0]                  w_new_rdy;
    logic [DATA_W-1:0]           w_new_val [3];

    assign disp_ready = (r_occ < OCC_W'(DEPTH));
    assign w_accept   = disp_valid & disp_ready;
    assign w_need     = operand_need(4'(disp_opcode));
    assign w_d_rdy    = {disp_t_rdy, disp_a_rdy, disp_b_rdy};

    always_comb begin
        w_d_tag[OPND_B] = disp_b_tag;
        w_d_tag[OPND_A] = disp_a_tag;
        w_d_tag[OPND_T] = disp_t_tag;
        w_d_val[OPND_B] = disp_b_val;
        w_d_val[OPND_A] = disp_a_val;
        w_d_val[OPND_T] = disp_t_val;
    end

    // Unneeded operands count as ready; a same-cycle CDB match is bypassed in
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_new_rdy[k] = 1'b1;
            w_new_val[k] = w_d_val[k];
            if (w_need[k] && !w_d_rdy[k]) begin
                if (cdb_valid && cdb_rob_index == w_d_tag[k]) begin
                    w_new_val[k] = cdb_value;
                end else begin
                    w_new_rdy[k] = 1'b0;
                    w_new_val[k] = '0;
                end
            end
        end
    end

    always_comb begin
        w_free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_sel_rdy[i] = r_valid[i] & (&r_rdy[i]);
        end
    end

    iq_oldest_picker #(
        .DEPTH (DEPTH),
        .AGE_W (AGE_W)
    ) u_picker (
        .i_ready (w_sel_rdy),
        .i_age   (r_age),
        .o_grant (w_grant),
        .o_any   (w_issue)
    );

    always_comb begin
        w_sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_grant[i]) begin
                w_sel_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid       <= '0;
            r_age_ctr     <= '0;
            r_occ         <= '0;
            r_age         <= '0;
            r_issue_valid <= 1'b0;
            r_issue_op    <= '0;
            r_issue_rob   <= '0;
            r_issue_vt    <= '0;
            r_issue_va    <= '0;
            r_issue_vb    <= '0;
            r_issue_i     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_op[i]  <= '0;
                r_rob[i] <= '0;
                r_imm[i] <= '0;
                r_rdy[i] <= '0;
                for (int k = 0; k < 3; k++) begin
                    r_tag[i][k] <= '0;
                    r_val[i][k] <= '0;
                end
            end
        end else if (flush) begin
            r_valid       <= '0;
            r_occ         <= '0;
            r_issue_valid <= 1'b0;
            r_issue_op    <= '0;
            r_issue_rob   <= '0;
            r_issue_vt    <= '0;
            r_issue_va    <= '0;
            r_issue_vb    <= '0;
            r_issue_i     <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_issue && w_grant[i]) begin
                    r_valid[i] <= 1'b0;
                end else if (r_valid[i]) begin
                    for (int k = 0; k < 3; k++) begin
                        if (!r_rdy[i][k] && cdb_valid && cdb_rob_index == r_tag[i][k]) begin
                            r_rdy[i][k] <= 1'b1;
                            r_val[i][k] <= cdb_value;
                        end
                    end
                end
                // The free slot is never the one being issued, so no write conflict
                if (w_accept && w_free_idx == IDX_W'(i)) begin
                    r_valid[i] <= 1'b1;
                    r_op[i]    <= disp_opcode;
                    r_rob[i]   <= disp_rob_index;
                    r_imm[i]   <= disp_imm;
                    r_age[i]   <= r_age_ctr;
                    r_rdy[i]   <= w_new_rdy;
                    for (int k = 0; k < 3; k++) begin
                        r_tag[i][k] <= w_d_tag[k];
                        r_val[i][k] <= w_new_val[k];
                    end
                end
            end
            if (w_accept) begin
                r_age_ctr <= r_age_ctr + AGE_W'(1);
            end
            r_occ         <= r_occ + OCC_W'(w_accept) - OCC_W'(w_issue);
            r_issue_valid <= w_issue;
            if (w_issue) begin
                r_issue_op  <= r_op[w_sel_idx];
                r_issue_rob <= r_rob[w_sel_idx];
                r_issue_vt  <= r_val[w_sel_idx][OPND_T];
                r_issue_va  <= r_val[w_sel_idx][OPND_A];
                r_issue_vb  <= r_val[w_sel_idx][OPND_B];
                r_issue_i   <= r_imm[w_sel_idx];
            end else begin
                r_issue_op  <= '0;
                r_issue_rob <= '0;
                r_issue_vt  <= '0;
                r_issue_va  <= '0;
                r_issue_vb  <= '0;
                r_issue_i   <= '0;
            end
        end
    end

    assign issue_valid     = r_issue_valid;
    assign issue_opcode    = r_issue_op;
    assign issue_rob_index = r_issue_rob;
    assign issue_vt        = r_issue_vt;
    assign issue_va        = r_issue_va;
    assign issue_vb        = r_issue_vb;
    assign issue_i         = r_issue_i;
    assign occupancy       = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_fxu_issue_queue.sv
`default_nettype none
// ============================================================================
// tb_fxu_issue_queue : directed bench with a sequence-number reference model
// Rev 1.0
// ============================================================================
module tb_fxu_issue_queue;

    localparam int DEPTH  = 4;
    localparam int ROB_W  = 4;
    localparam int DATA_W = 16;
    localparam int IMM_W  = 9;
    localparam int OP_W   = 4;

    localparam logic [3:0] C_ADD  = 4'b0000;
    localparam logic [3:0] C_SUB  = 4'b0001;
    localparam logic [3:0] C_MOV  = 4'b0100;
    localparam logic [3:0] C_MOVL = 4'b0101;
    localparam logic [3:0] C_MOVH = 4'b0110;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, flush, disp_valid, disp_ready;
    logic [OP_W-1:0]   disp_opcode;
    logic [ROB_W-1:0]  disp_rob_index;
    logic [IMM_W-1:0]  disp_imm;
    logic              disp_t_rdy, disp_a_rdy, disp_b_rdy;
    logic [ROB_W-1:0]  disp_t_tag, disp_a_tag, disp_b_tag;
    logic [DATA_W-1:0] disp_t_val, disp_a_val, disp_b_val;
    logic              cdb_valid;
    logic [ROB_W-1:0]  cdb_rob_index;
    logic [DATA_W-1:0] cdb_value;
    logic              issue_valid;
    logic [OP_W-1:0]   issue_opcode;
    logic [ROB_W-1:0]  issue_rob_index;
    logic [DATA_W-1:0] issue_vt, issue_va, issue_vb;
    logic [IMM_W-1:0]  issue_i;
    logic [2:0]        occupancy;

    fxu_issue_queue #(
        .DEPTH(DEPTH), .ROB_W(ROB_W), .DATA_W(DATA_W), .IMM_W(IMM_W), .OP_W(OP_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_opcode(disp_opcode), .disp_rob_index(disp_rob_index), .disp_imm(disp_imm),
        .disp_t_rdy(disp_t_rdy), .disp_t_tag(disp_t_tag), .disp_t_val(disp_t_val),
        .disp_a_rdy(disp_a_rdy), .disp_a_tag(disp_a_tag), .disp_a_val(disp_a_val),
        .disp_b_rdy(disp_b_rdy), .disp_b_tag(disp_b_tag), .disp_b_val(disp_b_val),
        .cdb_valid(cdb_valid), .cdb_rob_index(cdb_rob_index), .cdb_value(cdb_value),
        .issue_valid(issue_valid), .issue_opcode(issue_opcode),
        .issue_rob_index(issue_rob_index), .issue_vt(issue_vt), .issue_va(issue_va),
        .issue_vb(issue_vb), .issue_i(issue_i), .occupancy(occupancy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model: a bag of live ops, each stamped with an unbounded sequence number
    bit                m_v   [DEPTH];
    int                m_seq [DEPTH];
    logic [3:0]        m_op  [DEPTH];
    logic [ROB_W-1:0]  m_rob [DEPTH];
    logic [IMM_W-1:0]  m_imm [DEPTH];
    bit                m_rdy [DEPTH][3];
    logic [ROB_W-1:0]  m_tag [DEPTH][3];
    logic [DATA_W-1:0] m_val [DEPTH][3];
    int                m_cnt, m_next_seq;

    bit                e_iv;
    logic [3:0]        e_op;
    logic [ROB_W-1:0]  e_rob;
    logic [DATA_W-1:0] e_vt, e_va, e_vb;
    logic [IMM_W-1:0]  e_i;
    int                e_occ;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s : got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic bit [2:0] needs(input logic [3:0] op);
        // index 0 = b, 1 = a, 2 = t
        case (op)
            4'd0, 4'd1: return 3'b011;
            4'd4:       return 3'b010;
            4'd5, 4'd6: return 3'b100;
            default:    return 3'b000;
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
        m_cnt = 0;
        e_iv  = 1'b0;
        e_occ = 0;
    endtask

    task automatic model_update();
        int         best;
        int         cnt_before;
        bit [2:0]   nd;
        bit         drdy [3];
        logic [ROB_W-1:0]  dtag [3];
        logic [DATA_W-1:0] dval [3];
        if (rst || flush) begin
            model_clear();
        end else begin
            cnt_before = m_cnt;
            best = -1;
            for (int i = 0; i < DEPTH; i++) begin
                if (m_v[i] && m_rdy[i][0] && m_rdy[i][1] && m_rdy[i][2] &&
                    (best < 0 || m_seq[i] < m_seq[best])) best = i;
            end
            e_iv = (best >= 0);
            if (best >= 0) begin
                e_op  = m_op[best];
                e_rob = m_rob[best];
                e_vb  = m_val[best][0];
                e_va  = m_val[best][1];
                e_vt  = m_val[best][2];
                e_i   = m_imm[best];
                m_v[best] = 1'b0;
                m_cnt--;
            end
            if (cdb_valid) begin
                for (int i = 0; i < DEPTH; i++) begin
                    for (int k = 0; k < 3; k++) begin
                        if (m_v[i] && !m_rdy[i][k] && m_tag[i][k] == cdb_rob_index) begin
                            m_rdy[i][k] = 1'b1;
                            m_val[i][k] = cdb_value;
                        end
                    end
                end
            end
            if (disp_valid && cnt_before < DEPTH) begin
                drdy = '{disp_b_rdy, disp_a_rdy, disp_t_rdy};
                dtag = '{disp_b_tag, disp_a_tag, disp_t_tag};
                dval = '{disp_b_val, disp_a_val, disp_t_val};
                nd   = needs(disp_opcode);
                for (int i = 0; i < DEPTH; i++) begin
                    if (!m_v[i]) begin
                        m_v[i]   = 1'b1;
                        m_seq[i] = m_next_seq++;
                        m_op[i]  = disp_opcode;
                        m_rob[i] = disp_rob_index;
                        m_imm[i] = disp_imm;
                        for (int k = 0; k < 3; k++) begin
                            m_tag[i][k] = dtag[k];
                            if (!nd[k] || drdy[k]) begin
                                m_rdy[i][k] = 1'b1;
                                m_val[i][k] = dval[k];
                            end else if (cdb_valid && cdb_rob_index == dtag[k]) begin
                                m_rdy[i][k] = 1'b1;
                                m_val[i][k] = cdb_value;
                            end else begin
                                m_rdy[i][k] = 1'b0;
                            end
                        end
                        m_cnt++;
                        break;
                    end
                end
            end
            e_occ = m_cnt;
        end
    endtask

    // Per-cycle comparison, half a cycle after the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("issue_valid", issue_valid, e_iv);
                chk("occupancy", occupancy, e_occ);
                chk("disp_ready", disp_ready, e_occ < DEPTH);
                if (e_iv) begin
                    chk("issue_opcode", issue_opcode, e_op);
                    chk("issue_rob_index", issue_rob_index, e_rob);
                    chk("issue_vt", issue_vt, e_vt);
                    chk("issue_va", issue_va, e_va);
                    chk("issue_vb", issue_vb, e_vb);
                    chk("issue_i", issue_i, e_i);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        flush = 1'b0; disp_valid = 1'b0; disp_opcode = '0; disp_rob_index = '0; disp_imm = '0;
        disp_t_rdy = 1'b0; disp_t_tag = '0; disp_t_val = '0;
        disp_a_rdy = 1'b0; disp_a_tag = '0; disp_a_val = '0;
        disp_b_rdy = 1'b0; disp_b_tag = '0; disp_b_val = '0;
        cdb_valid = 1'b0; cdb_rob_index = '0; cdb_value = '0;
    endtask

    task automatic dispatch(input logic [3:0] op, input logic [3:0] rob, input logic [8:0] imm);
        idle();
        disp_valid = 1'b1; disp_opcode = op; disp_rob_index = rob; disp_imm = imm;
    endtask

    task automatic opnd_t(input logic r, input logic [3:0] tg, input logic [15:0] v);
        disp_t_rdy = r; disp_t_tag = tg; disp_t_val = v;
    endtask
    task automatic opnd_a(input logic r, input logic [3:0] tg, input logic [15:0] v);
        disp_a_rdy = r; disp_a_tag = tg; disp_a_val = v;
    endtask
    task automatic opnd_b(input logic r, input logic [3:0] tg, input logic [15:0] v);
        disp_b_rdy = r; disp_b_tag = tg; disp_b_val = v;
    endtask
    task automatic cdb(input logic [3:0] tg, input logic [15:0] v);
        cdb_valid = 1'b1; cdb_rob_index = tg; cdb_value = v;
    endtask

    initial begin
        m_next_seq = 0;
        rst = 1'b1;
        idle();
        model_clear();
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset occupancy", occupancy, 0);
        chk("reset disp_ready", disp_ready, 1);
        chk("reset issue_valid", issue_valid, 0);

        // Dispatch with all operands ready issues after the next edge
        dispatch(C_ADD, 4'd2, 9'd0); opnd_a(1, 0, 16'd5); opnd_b(1, 0, 16'd3);
        tick();
        chk("add queued occupancy", occupancy, 1);
        idle();
        tick();
        chk("add issue_valid", issue_valid, 1);
        chk("add va", issue_va, 16'd5);
        chk("add vb", issue_vb, 16'd3);
        chk("add rob", issue_rob_index, 4'd2);

        // Operand waiting on tag 7, woken two edges later
        dispatch(C_SUB, 4'd4, 9'd0); opnd_a(0, 4'd7, 0); opnd_b(1, 0, 16'd1);
        tick();
        idle();
        tick();
        chk("sub waits", issue_valid, 0);
        cdb(4'd7, 16'h0010);
        tick();
        chk("sub not yet", issue_valid, 0);
        idle();
        tick();
        chk("sub issue_valid", issue_valid, 1);
        chk("sub va", issue_va, 16'h0010);
        chk("sub rob", issue_rob_index, 4'd4);

        // Dispatch-time bypass of the same-cycle CDB
        dispatch(C_MOVL, 4'd1, 9'h1A5); opnd_t(0, 4'd9, 0); cdb(4'd9, 16'hABCD);
        tick();
        idle();
        tick();
        chk("movl issue_valid", issue_valid, 1);
        chk("movl vt", issue_vt, 16'hABCD);
        chk("movl imm", issue_i, 9'h1A5);

        // Fill, drop when full, one CDB wakes two entries
        dispatch(C_ADD, 4'd8, 0);   opnd_a(0, 4'd3, 0); opnd_b(1, 0, 16'd2); tick();
        dispatch(C_MOV, 4'd9, 0);   opnd_a(0, 4'd5, 0); tick();
        dispatch(C_SUB, 4'd10, 0);  opnd_a(1, 0, 16'd7); opnd_b(0, 4'd3, 0); tick();
        dispatch(C_MOVH, 4'd11, 9'h0F0); opnd_t(0, 4'd6, 0); tick();
        chk("full disp_ready", disp_ready, 0);
        chk("full occupancy", occupancy, 4);
        dispatch(C_ADD, 4'd12, 0); opnd_a(1, 0, 16'd1); opnd_b(1, 0, 16'd1); tick();
        chk("dropped occupancy", occupancy, 4);
        idle(); cdb(4'd3, 16'h0033); tick();
        idle(); tick();
        chk("older first rob", issue_rob_index, 4'd8);
        chk("older first va", issue_va, 16'h0033);
        dispatch(C_ADD, 4'd12, 0); opnd_a(1, 0, 16'd1); opnd_b(1, 0, 16'd1); tick();
        chk("second rob", issue_rob_index, 4'd10);
        chk("second vb", issue_vb, 16'h0033);
        chk("disp+issue occupancy", occupancy, 3);
        idle(); tick();
        idle(); cdb(4'd6, 16'h0606); tick();
        idle(); cdb(4'd5, 16'h0505); tick();
        chk("movh rob", issue_rob_index, 4'd11);
        idle(); cdb(4'd15, 16'hFFFF); tick();
        chk("mov rob", issue_rob_index, 4'd9);
        idle(); cdb(4'd5, 16'h1111); tick();
        chk("drained occupancy", occupancy, 0);

        // Stream of ready ops with one older waiter across age-stamp wrap
        for (int i = 0; i < 18; i++) begin
            dispatch(C_ADD, 4'(i), 0); opnd_a(1, 0, 16'(i)); opnd_b(1, 0, 16'd100); tick();
        end
        dispatch(C_MOV, 4'd3, 0); opnd_a(0, 4'd14, 0); tick();
        for (int i = 0; i < 8; i++) begin
            dispatch(C_SUB, 4'(i + 4), 0); opnd_a(1, 0, 16'(i + 200)); opnd_b(1, 0, 16'd9);
            if (i == 6) cdb(4'd14, 16'h0E0E);
            tick();
        end
        idle(); tick();
        idle(); tick();
        idle(); tick();

        // Flush beats same-cycle dispatch and wakeup
        dispatch(C_ADD, 4'd5, 0); opnd_a(0, 4'd2, 0); opnd_b(1, 0, 16'd1); tick();
        dispatch(C_ADD, 4'd6, 0); opnd_a(1, 0, 16'd1); opnd_b(1, 0, 16'd1);
        cdb(4'd2, 16'h0022); flush = 1'b1;
        tick();
        chk("flush occupancy", occupancy, 0);
        chk("flush issue_valid", issue_valid, 0);
        idle(); tick();
        chk("post flush issue_valid", issue_valid, 0);

        // Asynchronous reset with three entries in flight
        dispatch(C_ADD, 4'd1, 0); opnd_a(0, 4'd8, 0); tick();
        dispatch(C_MOV, 4'd2, 0); opnd_a(0, 4'd8, 0); tick();
        dispatch(C_MOVL, 4'd3, 0); opnd_t(0, 4'd8, 0); tick();
        chk("pre reset occupancy", occupancy, 3);
        idle();
        rst = 1'b1;
        model_clear();
        #1;
        chk("mid reset occupancy", occupancy, 0);
        chk("mid reset issue_valid", issue_valid, 0);
        chk("mid reset disp_ready", disp_ready, 1);
        tick();
        rst = 1'b0;
        cdb(4'd8, 16'h0808); tick();
        idle(); tick();
        chk("after reset no issue", issue_valid, 0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
